stack_alu_sequencer: RTL and testbench
======================================

STACK_ALU_SEQUENCER -- requirements
Module: stack_alu_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, meaning the ALU data width in bits.
REQ-002 SHALL have parameter DEPTH, default 200, meaning the maximum stack entries the sequencer permits.
REQ-003 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit; command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit; command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 SHALL have port cmd_op, input, 3 bits; opcode: 100 add, 101 mul, 110 push, 111 pop; 0xx is illegal.
REQ-008 SHALL have port cmd_data, input, N bits, signed; push operand.
REQ-009 SHALL have port rsp_valid, output, 1 bit; response available.
REQ-010 SHALL have port rsp_ready, input, 1 bit; response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-011 SHALL have port rsp_data, output, N bits, signed; result of add, mul or pop.
REQ-012 SHALL have port rsp_overflow, output, 1 bit; ALU overflow flag for the command.
REQ-013 SHALL have port rsp_error, output, 1 bit; command rejected, ALU not driven.
REQ-014 SHALL have port alu_opcode, output, 3 bits; opcode driven to the stack ALU.
REQ-015 SHALL have port alu_input_data, output, N bits; push data driven to the stack ALU.
REQ-016 SHALL have port alu_output_data, input, N bits; ALU result.
REQ-017 SHALL have port alu_overflow, input, 1 bit; ALU overflow.
REQ-018 SHALL have port depth, output, $clog2(DEPTH+1) bits; tracked stack occupancy.
REQ-019 SHALL have port err_count, output, 8 bits; number of rejected commands.

Function
REQ-020 SHALL implement FSM states IDLE, EXEC and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance in IDLE, SHALL latch cmd_op/cmd_data and check legality against current depth: illegal opcode; push with depth==DEPTH; pop with depth==0; add/mul with depth<2.
REQ-022 Illegal command: IDLE->RESP; rsp_error=1, rsp_data=0, rsp_overflow=0, ALU not driven, depth unchanged, err_count incremented, saturating at 255.
REQ-023 Legal command: IDLE->EXEC for exactly one cycle; alu_opcode=latched op; alu_input_data=latched data (push) else 0.
REQ-024 At the rising edge ending EXEC: SHALL register rsp_data=alu_output_data for add/mul/pop and 0 for push; SHALL register rsp_overflow=alu_overflow for add/mul and 0 otherwise; SHALL set rsp_error=0; SHALL go to RESP.
REQ-025 Depth update at the end of EXEC: push +1, pop -1, add/mul unchanged.
REQ-026 alu_opcode SHALL be 000 in IDLE and RESP, so each command hits the ALU for exactly one cycle.
REQ-027 RESP: rsp_valid=1, with rsp_data/rsp_overflow/rsp_error held stable until rsp_ready; on handshake SHALL go to IDLE and clear rsp_valid.
REQ-028 Latency, legal command: accept edge k; EXEC during cycle k..k+1; rsp_valid high after edge k+1. Illegal command: rsp_valid high after edge k.
REQ-029 Throughput: new command accepted at earliest the edge after response handshake; cmd_valid outside IDLE ignored.
REQ-030 Exactly one response per accepted command; never a response without a command.
REQ-031 depth SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-032 rst high SHALL immediately force IDLE, depth=0, err_count=0, rsp_valid=0, rsp_data=0, rsp_overflow=0, rsp_error=0, alu_opcode=000, alu_input_data=0, and cmd_ready=0 while rst is high.
REQ-033 Reset during EXEC or RESP SHALL discard the in-flight command without a response; cmd_ready=1 from the first edge after rst deasserts.

Verification
REQ-034 Push 5, push 3, add (N=8) -> three responses; add rsp_data=8, overflow=0, depth=2.
REQ-035 Push 100, push 100, add -> rsp_data=-56, rsp_overflow=1; then mul -> rsp_data=16, rsp_overflow=1.
REQ-036 Pop on empty; add with depth 1; cmd_op=010 -> each rsp_error=1 with rsp_valid one cycle after accept, depth unchanged, err_count=3, alu_opcode stays 000.
REQ-037 DEPTH=4: push x5 -> fifth rsp_error=1, depth=4; pop x4 -> LIFO data order, depth=0.
REQ-038 Hold rsp_ready=0 for 10 cycles after push 7, pop -> rsp_data=7 stable, cmd_ready=0 throughout; single response on release.
REQ-039 Assert rst during EXEC of a push at depth 2 -> no response, depth=0, alu_opcode=000 immediately, cmd_ready=1 after deassert.

Source files
------------

// File: rtl/stack_alu_sequencer.sv
// Command sequencer in front of an external stack ALU: checks each command against
// the tracked stack depth, drives the ALU for one cycle and holds a single response.
module stack_alu_sequencer #(
   parameter int N     = 8,
   parameter int DEPTH = 200
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [2:0]                   cmd_op,
   input  logic signed [N-1:0]          cmd_data,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic signed [N-1:0]          rsp_data,
   output logic                         rsp_overflow,
   output logic                         rsp_error,
   output logic [2:0]                   alu_opcode,
   output logic [N-1:0]                 alu_input_data,
   input  logic [N-1:0]                 alu_output_data,
   input  logic                         alu_overflow,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic [7:0]                   err_count
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   // Handshakes: a command transfers when cmd_valid && cmd_ready at a rising edge;
   // a response transfers when rsp_valid && rsp_ready at a rising edge.
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q;
   logic [2:0]          alu_opcode_q;
   logic [N-1:0]        alu_input_q;
   logic signed [N-1:0] rsp_data_q;
   logic                rsp_ovf_q;
   logic                rsp_err_q;
   logic [DW-1:0]       depth_q, depth_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic                cmd_legal;
   logic                is_push, is_pop, is_arith;

   always_comb begin
      is_push   = (cmd_op == OP_PUSH);
      is_pop    = (cmd_op == OP_POP);
      is_arith  = (cmd_op == OP_ADD) || (cmd_op == OP_MUL);
      cmd_legal = cmd_op[2]
                  && !(is_push && (depth_q == DEPTH_MAX))
                  && !(is_pop && (depth_q == '0))
                  && !(is_arith && ({{(32-DW){1'b0}}, depth_q} < 32'd2));
   end

   // Depth only moves when a push/pop actually reaches the ALU.
   always_comb begin
      depth_d   = depth_q;
      err_cnt_d = err_cnt_q;
      if (state_q == EXEC) begin
         if (alu_opcode_q == OP_PUSH)
            depth_d = depth_q + DW'(1);
         else if (alu_opcode_q == OP_POP)
            depth_d = depth_q - DW'(1);
      end
      if ((state_q == IDLE) && cmd_valid && !cmd_legal && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         alu_opcode_q <= OP_NONE;
         alu_input_q  <= '0;
         rsp_data_q   <= '0;
         rsp_ovf_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         depth_q      <= '0;
         err_cnt_q    <= '0;
      end else begin
         depth_q   <= depth_d;
         err_cnt_q <= err_cnt_d;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_legal) begin
                     alu_opcode_q <= cmd_op;
                     alu_input_q  <= is_push ? cmd_data : '0;
                     state_q      <= EXEC;
                  end else begin
                     rsp_data_q <= '0;
                     rsp_ovf_q  <= 1'b0;
                     rsp_err_q  <= 1'b1;
                     state_q    <= RESP;
                  end
               end
            end
            EXEC: begin
               rsp_data_q   <= (alu_opcode_q == OP_PUSH) ? '0 : alu_output_data;
               rsp_ovf_q    <= ((alu_opcode_q == OP_ADD) || (alu_opcode_q == OP_MUL))
                               ? alu_overflow : 1'b0;
               rsp_err_q    <= 1'b0;
               alu_opcode_q <= OP_NONE;
               alu_input_q  <= '0;
               state_q      <= RESP;
            end
            RESP: begin
               if (rsp_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready      = (state_q == IDLE) && !rst;
   assign rsp_valid      = (state_q == RESP);
   assign rsp_data       = rsp_data_q;
   assign rsp_overflow   = rsp_ovf_q;
   assign rsp_error      = rsp_err_q;
   assign alu_opcode     = alu_opcode_q;
   assign alu_input_data = alu_input_q;
   assign depth          = depth_q;
   assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a small behavioural stack ALU attached.
module tb_stack_alu_sequencer;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [N-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          rsp_overflow;
  logic          rsp_error;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_input_data;
  logic [N-1:0]  alu_output_data;
  logic          alu_overflow;
  logic [DW-1:0] depth;
  logic [7:0]    err_count;

  int compared   = 0;
  int mismatched = 0;

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_overflow   (rsp_overflow),
    .rsp_error      (rsp_error),
    .alu_opcode     (alu_opcode),
    .alu_input_data (alu_input_data),
    .alu_output_data(alu_output_data),
    .alu_overflow   (alu_overflow),
    .depth          (depth),
    .err_count      (err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stack ALU: add/mul read the top two entries without popping; pop returns top.
  logic signed [N-1:0]   stk [0:7];
  logic [2:0]            sp;
  logic signed [N-1:0]   top, nxt;
  logic signed [N:0]     sum;
  logic signed [2*N-1:0] prod;

  always_comb begin
    top  = (sp > 3'd0) ? stk[sp - 3'd1] : '0;
    nxt  = (sp > 3'd1) ? stk[sp - 3'd2] : '0;
    sum  = {top[N-1], top} + {nxt[N-1], nxt};
    prod = top * nxt;
    alu_output_data = '0;
    alu_overflow    = 1'b0;
    case (alu_opcode)
      3'b100: begin
        alu_output_data = sum[N-1:0];
        alu_overflow    = (sum[N] != sum[N-1]);
      end
      3'b101: begin
        alu_output_data = prod[N-1:0];
        alu_overflow    = (prod != {{N{prod[N-1]}}, prod[N-1:0]});
      end
      3'b111: alu_output_data = top;
      default: ;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 3'd0;
    end else if (alu_opcode == 3'b110) begin
      stk[sp] <= alu_input_data;
      sp      <= sp + 3'd1;
    end else if (alu_opcode == 3'b111) begin
      sp <= sp - 3'd1;
    end
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: issue one command, follow it to its response and release it
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [N-1:0] data,
                        input logic exp_err, input logic [N-1:0] exp_data,
                        input logic exp_ovf, input logic [DW-1:0] exp_depth);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "/ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "/early_valid"}, {31'd0, rsp_valid}, {31'd0, exp_err});
    check({tag, "/exec_op"}, {29'd0, alu_opcode}, exp_err ? 32'd0 : {29'd0, op});
    if (!exp_err) begin
      check({tag, "/exec_data"}, {24'd0, alu_input_data}, (op == 3'b110) ? {24'd0, data} : 32'd0);
      @(posedge clk); #1;
    end
    check({tag, "/rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "/rsp_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
    check({tag, "/rsp_ovf"}, {31'd0, rsp_overflow}, {31'd0, exp_ovf});
    check({tag, "/rsp_err"}, {31'd0, rsp_error}, {31'd0, exp_err});
    check({tag, "/alu_idle"}, {29'd0, alu_opcode}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "/rsp_clear"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "/depth"}, {29'd0, depth}, {29'd0, exp_depth});
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #2;
    check("rst/cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst/depth", {29'd0, depth}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst/ready_after", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset/rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset/rsp_data", {24'd0, rsp_data}, 32'd0);
    check("reset/alu_opcode", {29'd0, alu_opcode}, 32'd0);
    check("reset/depth", {29'd0, depth}, 32'd0);
    check("reset/err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset/ready_after", {31'd0, cmd_ready}, 32'd1);

    // basic add, then LIFO drain
    do_cmd("push5", 3'b110, 8'd5, 1'b0, 8'd0, 1'b0, 3'd1);
    do_cmd("push3", 3'b110, 8'd3, 1'b0, 8'd0, 1'b0, 3'd2);
    do_cmd("add8",  3'b100, 8'd0, 1'b0, 8'd8, 1'b0, 3'd2);
    do_cmd("pop3",  3'b111, 8'd0, 1'b0, 8'd3, 1'b0, 3'd1);
    do_cmd("pop5",  3'b111, 8'd0, 1'b0, 8'd5, 1'b0, 3'd0);

    // overflow: 100+100 = -56, 100*100 -> 16
    do_cmd("push100a", 3'b110, 8'd100, 1'b0, 8'd0,   1'b0, 3'd1);
    do_cmd("push100b", 3'b110, 8'd100, 1'b0, 8'd0,   1'b0, 3'd2);
    do_cmd("add_ovf",  3'b100, 8'd0,   1'b0, 8'hC8,  1'b1, 3'd2);
    do_cmd("mul_ovf",  3'b101, 8'd0,   1'b0, 8'd16,  1'b1, 3'd2);
    do_cmd("pop100a",  3'b111, 8'd0,   1'b0, 8'd100, 1'b0, 3'd1);
    do_cmd("pop100b",  3'b111, 8'd0,   1'b0, 8'd100, 1'b0, 3'd0);

    // rejected commands
    do_cmd("pop_empty",  3'b111, 8'd0,  1'b1, 8'd0, 1'b0, 3'd0);
    do_cmd("push1",      3'b110, 8'd1,  1'b0, 8'd0, 1'b0, 3'd1);
    do_cmd("add_shallow",3'b100, 8'd0,  1'b1, 8'd0, 1'b0, 3'd1);
    do_cmd("op010",      3'b010, 8'd77, 1'b1, 8'd0, 1'b0, 3'd1);
    check("err_count3", {24'd0, err_count}, 32'd3);
    do_cmd("pop1",       3'b111, 8'd0,  1'b0, 8'd1, 1'b0, 3'd0);

    // full stack at DEPTH=4
    do_cmd("fill1", 3'b110, 8'd1, 1'b0, 8'd0, 1'b0, 3'd1);
    do_cmd("fill2", 3'b110, 8'd2, 1'b0, 8'd0, 1'b0, 3'd2);
    do_cmd("fill3", 3'b110, 8'd3, 1'b0, 8'd0, 1'b0, 3'd3);
    do_cmd("fill4", 3'b110, 8'd4, 1'b0, 8'd0, 1'b0, 3'd4);
    do_cmd("fill5", 3'b110, 8'd5, 1'b1, 8'd0, 1'b0, 3'd4);
    check("err_count4", {24'd0, err_count}, 32'd4);
    do_cmd("drain4", 3'b111, 8'd0, 1'b0, 8'd4, 1'b0, 3'd3);
    do_cmd("drain3", 3'b111, 8'd0, 1'b0, 8'd3, 1'b0, 3'd2);
    do_cmd("drain2", 3'b111, 8'd0, 1'b0, 8'd2, 1'b0, 3'd1);
    do_cmd("drain1", 3'b111, 8'd0, 1'b0, 8'd1, 1'b0, 3'd0);

    // response backpressure; a command offered meanwhile must be ignored
    do_cmd("push7", 3'b110, 8'd7, 1'b0, 8'd0, 1'b0, 3'd1);
    cmd_valid = 1'b1;
    cmd_op    = 3'b111;
    @(posedge clk); #1;
    cmd_op    = 3'b110;
    cmd_data  = 8'd55;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check("hold/rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold/rsp_data", {24'd0, rsp_data}, 32'd7);
      check("hold/cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hold/released", {31'd0, rsp_valid}, 32'd0);
    check("hold/depth", {29'd0, depth}, 32'd0);
    @(posedge clk); #1;
    check("hold/single_rsp", {31'd0, rsp_valid}, 32'd0);
    check("hold/depth_after", {29'd0, depth}, 32'd0);

    // reset while a push is in EXEC
    reset_dut();
    do_cmd("rpush1", 3'b110, 8'd1, 1'b0, 8'd0, 1'b0, 3'd1);
    do_cmd("rpush2", 3'b110, 8'd2, 1'b0, 8'd0, 1'b0, 3'd2);
    cmd_valid = 1'b1;
    cmd_op    = 3'b110;
    cmd_data  = 8'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rexec/alu_opcode", {29'd0, alu_opcode}, 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check("rexec/alu_cleared", {29'd0, alu_opcode}, 32'd0);
    check("rexec/depth", {29'd0, depth}, 32'd0);
    check("rexec/cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rexec/rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rexec/ready_after", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("rexec/no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check("rexec/depth_after", {29'd0, depth}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
